// File: rtl/hms_time_core.sv
// Hours:minutes:seconds timekeeping core with 12h/24h format, up/down counting,
// validated parallel load and per-field set increments.
module hms_time_core #(
  parameter bit MODE_12H    = 1'b0,
  parameter bit SAT_ON_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       down,
  input  logic       clear,
  input  logic       load,
  input  logic [4:0] load_h,
  input  logic [5:0] load_m,
  input  logic [5:0] load_s,
  input  logic       load_pm,
  input  logic       inc,
  input  logic [1:0] inc_sel,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic       day_wrap,
  output logic       at_zero,
  output logic       load_err
);

  localparam logic [4:0] H_ZERO    = MODE_12H ? 5'd12 : 5'd0;
  localparam logic [4:0] H_TOP_MAX = MODE_12H ? 5'd11 : 5'd23;

  logic [4:0] r_hours;
  logic [5:0] r_minutes;
  logic [5:0] r_seconds;
  logic       r_pm;
  logic       r_day_wrap;
  logic       r_load_err;

  logic [4:0] w_hours_nxt;
  logic [5:0] w_minutes_nxt;
  logic [5:0] w_seconds_nxt;
  logic       w_pm_nxt;
  logic       w_day_wrap_nxt;
  logic       w_load_err_nxt;
  logic       w_at_zero;
  logic       w_hours_ok;
  logic       w_load_ok;

  assign w_at_zero  = (r_hours == H_ZERO) && (r_minutes == 6'd0) &&
                      (r_seconds == 6'd0) && !r_pm;
  assign w_hours_ok = MODE_12H ? ((load_h != 5'd0) && (load_h <= 5'd12))
                               : (load_h <= 5'd23);
  assign w_load_ok  = w_hours_ok && (load_m <= 6'd59) && (load_s <= 6'd59);

  always_comb begin
    w_hours_nxt    = r_hours;
    w_minutes_nxt  = r_minutes;
    w_seconds_nxt  = r_seconds;
    w_pm_nxt       = r_pm;
    w_day_wrap_nxt = 1'b0;
    w_load_err_nxt = 1'b0;

    if (clear) begin
      w_hours_nxt   = H_ZERO;
      w_minutes_nxt = 6'd0;
      w_seconds_nxt = 6'd0;
      w_pm_nxt      = 1'b0;
    end else if (load) begin
      if (w_load_ok) begin
        w_hours_nxt   = load_h;
        w_minutes_nxt = load_m;
        w_seconds_nxt = load_s;
        w_pm_nxt      = load_pm;
      end else begin
        w_load_err_nxt = 1'b1;
      end
    end else if (inc) begin
      // Set buttons adjust one field in isolation; no carries, no day_wrap.
      case (inc_sel)
        2'd0: w_seconds_nxt = (r_seconds == 6'd59) ? 6'd0 : r_seconds + 6'd1;
        2'd1: w_minutes_nxt = (r_minutes == 6'd59) ? 6'd0 : r_minutes + 6'd1;
        2'd2: begin
          if (MODE_12H) begin
            if (r_hours == 5'd12) begin
              w_hours_nxt = 5'd1;
            end else begin
              w_hours_nxt = r_hours + 5'd1;
              if (r_hours == 5'd11) w_pm_nxt = ~r_pm;
            end
          end else begin
            w_hours_nxt = (r_hours == 5'd23) ? 5'd0 : r_hours + 5'd1;
          end
        end
        default: ;
      endcase
    end else if (tick) begin
      if (!down) begin
        if (r_seconds == 6'd59) begin
          w_seconds_nxt = 6'd0;
          if (r_minutes == 6'd59) begin
            w_minutes_nxt = 6'd0;
            if (MODE_12H) begin
              if (r_hours == 5'd12) begin
                w_hours_nxt = 5'd1;
              end else begin
                w_hours_nxt = r_hours + 5'd1;
                // Midnight is the pm -> am transition at 11:59:59 -> 12:00:00.
                if (r_hours == 5'd11) begin
                  w_pm_nxt       = ~r_pm;
                  w_day_wrap_nxt = r_pm;
                end
              end
            end else if (r_hours == 5'd23) begin
              w_hours_nxt    = 5'd0;
              w_day_wrap_nxt = 1'b1;
            end else begin
              w_hours_nxt = r_hours + 5'd1;
            end
          end else begin
            w_minutes_nxt = r_minutes + 6'd1;
          end
        end else begin
          w_seconds_nxt = r_seconds + 6'd1;
        end
      end else if (w_at_zero) begin
        if (!SAT_ON_ZERO) begin
          w_hours_nxt    = H_TOP_MAX;
          w_minutes_nxt  = 6'd59;
          w_seconds_nxt  = 6'd59;
          w_pm_nxt       = MODE_12H;
          w_day_wrap_nxt = 1'b1;
        end
      end else begin
        // Not at zero time, so a borrow into hours never underflows 24h hour 0.
        if (r_seconds == 6'd0) begin
          w_seconds_nxt = 6'd59;
          if (r_minutes == 6'd0) begin
            w_minutes_nxt = 6'd59;
            if (MODE_12H && (r_hours == 5'd1)) begin
              w_hours_nxt = 5'd12;
            end else begin
              w_hours_nxt = r_hours - 5'd1;
              if (MODE_12H && (r_hours == 5'd12)) w_pm_nxt = ~r_pm;
            end
          end else begin
            w_minutes_nxt = r_minutes - 6'd1;
          end
        end else begin
          w_seconds_nxt = r_seconds - 6'd1;
        end
      end
    end

    if (!MODE_12H) w_pm_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hours    <= H_ZERO;
      r_minutes  <= 6'd0;
      r_seconds  <= 6'd0;
      r_pm       <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_hours    <= w_hours_nxt;
      r_minutes  <= w_minutes_nxt;
      r_seconds  <= w_seconds_nxt;
      r_pm       <= w_pm_nxt;
      r_day_wrap <= w_day_wrap_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign hours    = r_hours;
  assign minutes  = r_minutes;
  assign seconds  = r_seconds;
  assign pm       = r_pm;
  assign day_wrap = r_day_wrap;
  assign at_zero  = w_at_zero;
  assign load_err = r_load_err;

endmodule
